// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-master SDRAM arbiter.
package sdram_arb_pkg;
  localparam int NUM_MASTERS = 3;

  localparam logic [1:0] MASTER_ICACHE = 2'd0;
  localparam logic [1:0] MASTER_DCACHE = 2'd1;
  localparam logic [1:0] MASTER_VIDEO  = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    WAIT_BURST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       burst;
    logic [1:0] id;
  } cfifo_entry_t;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] id2oh(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  function automatic logic [1:0] oh2id(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction
endpackage

// File: rtl/sdram_arbiter_if.sv
// Master-side and controller-side buses of the SDRAM arbiter; slave is the arbiter view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 26
) ();
  logic              m0_req, m1_req, m2_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr;
  logic              m0_write, m1_write, m2_write;
  logic              m0_burst, m1_burst, m2_burst;
  logic [3:0]        m0_byte_enable, m1_byte_enable, m2_byte_enable;
  logic [31:0]       m0_wdata, m1_wdata, m2_wdata;
  logic              m0_ack, m1_ack, m2_ack;
  logic              m0_rdvalid, m1_rdvalid, m2_rdvalid;
  logic              m0_complete, m1_complete, m2_complete;
  logic [31:0]       rdata;

  logic [2:0]        sdram_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_write;
  logic              sdram_burst;
  logic [3:0]        sdram_byte_enable;
  logic [31:0]       sdram_wdata;
  logic              sdram_ack;
  logic [31:0]       sdram_rdata;
  logic [2:0]        sdram_rdvalid;
  logic              sdram_complete;
  logic              arb_error;

  modport slave (
    input  m0_req, m1_req, m2_req, m0_addr, m1_addr, m2_addr,
           m0_write, m1_write, m2_write, m0_burst, m1_burst, m2_burst,
           m0_byte_enable, m1_byte_enable, m2_byte_enable,
           m0_wdata, m1_wdata, m2_wdata,
    output m0_ack, m1_ack, m2_ack, m0_rdvalid, m1_rdvalid, m2_rdvalid,
           m0_complete, m1_complete, m2_complete, rdata,
    output sdram_req, sdram_addr, sdram_write, sdram_burst,
           sdram_byte_enable, sdram_wdata, arb_error,
    input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );

  modport master (
    output m0_req, m1_req, m2_req, m0_addr, m1_addr, m2_addr,
           m0_write, m1_write, m2_write, m0_burst, m1_burst, m2_burst,
           m0_byte_enable, m1_byte_enable, m2_byte_enable,
           m0_wdata, m1_wdata, m2_wdata,
    input  m0_ack, m1_ack, m2_ack, m0_rdvalid, m1_rdvalid, m2_rdvalid,
           m0_complete, m1_complete, m2_complete, rdata,
    input  sdram_req, sdram_addr, sdram_write, sdram_burst,
           sdram_byte_enable, sdram_wdata, arb_error,
    output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );
endinterface

// File: rtl/sdram_arb_cfifo.sv
// Completion FIFO: one entry per accepted read, popped on each controller completion pulse.
module sdram_arb_cfifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  cfifo_entry_t push_entry_i,
  input  logic         pop_i,
  output cfifo_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         underflow_o
);
  localparam int AW = $clog2(DEPTH);

  cfifo_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o      = (cnt_q == DEPTH[AW:0]);
  assign empty_o     = (cnt_q == '0);
  assign underflow_o = pop_i & empty_o;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign head_o      = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_entry_i;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Three-master round-robin arbiter in front of sdram_controller.
// Optional build macro SDRAM_ARB_VIDEO_PRIORITY_EN gives M2 absolute priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int CFIFO_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  sdram_arbiter_if.slave bus
);
  logic [2:0]                   req, wr, bu;
  logic [2:0][ADDR_W-1:0]       addr;
  logic [2:0][3:0]              be;
  logic [2:0][31:0]             wd;

  assign req     = {bus.m2_req,   bus.m1_req,   bus.m0_req};
  assign wr      = {bus.m2_write, bus.m1_write, bus.m0_write};
  assign bu      = {bus.m2_burst, bus.m1_burst, bus.m0_burst};
  assign addr[0] = bus.m0_addr;
  assign addr[1] = bus.m1_addr;
  assign addr[2] = bus.m2_addr;
  assign be[0]   = bus.m0_byte_enable;
  assign be[1]   = bus.m1_byte_enable;
  assign be[2]   = bus.m2_byte_enable;
  assign wd[0]   = bus.m0_wdata;
  assign wd[1]   = bus.m1_wdata;
  assign wd[2]   = bus.m2_wdata;

  arb_state_t   state_q, state_d;
  logic [2:0]   grant_q, grant_d;
  logic [1:0]   last_q, last_d;
  logic         err_q, err_d;

  logic [1:0]   sel_id;
  logic         push, full, empty, underflow;
  cfifo_entry_t push_entry, head;
  logic [2:0]   elig;
  logic         win_vld;
  logic [1:0]   win_id, cand;
  logic [2:0]   cmpl;

  assign sel_id     = oh2id(grant_q);
  assign push       = (state_q == GRANTED) & bus.sdram_ack & ~wr[sel_id];
  assign push_entry = '{burst: bu[sel_id], id: sel_id};

  sdram_arb_cfifo #(.DEPTH(CFIFO_DEPTH)) u_cfifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (bus.sdram_complete),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .underflow_o  (underflow)
  );

  // A read is only eligible while there is room to record its completion.
  assign elig = req & (wr | {3{~full}});

  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    cand    = rr_next(last_q);
`ifdef SDRAM_ARB_VIDEO_PRIORITY_EN
    if (elig[MASTER_VIDEO]) begin
      win_vld = 1'b1;
      win_id  = MASTER_VIDEO;
    end else begin
      cand = (last_q == MASTER_ICACHE) ? MASTER_DCACHE : MASTER_ICACHE;
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end else if (elig[cand ^ 2'd1]) begin
        win_vld = 1'b1;
        win_id  = cand ^ 2'd1;
      end
    end
`else
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
      cand = rr_next(cand);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q | underflow | (bus.sdram_ack & (grant_q == '0));
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = id2oh(win_id);
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (bus.sdram_ack) begin
          grant_d = '0;
          state_d = (~wr[sel_id] & bu[sel_id]) ? WAIT_BURST : IDLE;
`ifdef SDRAM_ARB_VIDEO_PRIORITY_EN
          if (sel_id != MASTER_VIDEO) last_d = sel_id;
`else
          last_d = sel_id;
`endif
        end
      end
      WAIT_BURST: begin
        // Single-read completions ahead of the burst do not end the wait.
        if (bus.sdram_complete & ~empty & head.burst) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign cmpl = {3{bus.sdram_complete & ~empty}} & id2oh(head.id);

  assign bus.sdram_req         = grant_q;
  assign bus.sdram_addr        = addr[sel_id];
  assign bus.sdram_write       = wr[sel_id];
  assign bus.sdram_burst       = bu[sel_id];
  assign bus.sdram_byte_enable = be[sel_id];
  assign bus.sdram_wdata       = wd[sel_id];
  assign bus.arb_error         = err_q;
  assign bus.rdata             = bus.sdram_rdata;

  assign bus.m0_ack      = bus.sdram_ack & grant_q[0];
  assign bus.m1_ack      = bus.sdram_ack & grant_q[1];
  assign bus.m2_ack      = bus.sdram_ack & grant_q[2];
  assign bus.m0_rdvalid  = bus.sdram_rdvalid[0];
  assign bus.m1_rdvalid  = bus.sdram_rdvalid[1];
  assign bus.m2_rdvalid  = bus.sdram_rdvalid[2];
  assign bus.m0_complete = cmpl[0];
  assign bus.m1_complete = cmpl[1];
  assign bus.m2_complete = cmpl[2];
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed, table-driven bench for sdram_arbiter; completion routing uses an issue-order queue.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W = 26;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .CFIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string      name;
    logic [2:0] req, wr, bu;
    logic       ack, cmpl;
    logic [2:0] rdv;
    logic [2:0] e_req, e_ack;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];
  int   sb[$];
  int   errs   = 0;
  int   checks = 0;

  logic [ADDR_W-1:0] m_addr [3];
  logic [3:0]        m_be   [3];
  logic [31:0]       m_wd   [3];

  function automatic vec_t mk(string n, logic [2:0] req, logic [2:0] wr, logic [2:0] bu,
                              logic ack, logic cmpl, logic [2:0] rdv,
                              logic [2:0] e_req, logic [2:0] e_ack, logic e_err);
    vec_t v;
    v.name = n; v.req = req; v.wr = wr; v.bu = bu; v.ack = ack; v.cmpl = cmpl;
    v.rdv = rdv; v.e_req = e_req; v.e_ack = e_ack; v.e_err = e_err;
    return v;
  endfunction

  function automatic int oh_idx(logic [2:0] o);
    return o[2] ? 2 : (o[1] ? 1 : 0);
  endfunction

  task automatic chk(string n, string f, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s.%s: got %0h, required %0h", n, f, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.m0_req = 0; bus.m1_req = 0; bus.m2_req = 0;
    bus.m0_write = 0; bus.m1_write = 0; bus.m2_write = 0;
    bus.m0_burst = 0; bus.m1_burst = 0; bus.m2_burst = 0;
    bus.sdram_ack = 0; bus.sdram_complete = 0; bus.sdram_rdvalid = 0; bus.sdram_rdata = 0;
  endtask

  task automatic do_reset(int n);
    @(negedge clock);
    reset = 1'b1;
    drive_idle();
    repeat (n) @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic apply(vec_t v);
    logic [2:0]  e_cmpl;
    logic [31:0] rd;
    int          g;
    @(negedge clock);
    bus.m0_req = v.req[0];   bus.m1_req = v.req[1];   bus.m2_req = v.req[2];
    bus.m0_write = v.wr[0];  bus.m1_write = v.wr[1];  bus.m2_write = v.wr[2];
    bus.m0_burst = v.bu[0];  bus.m1_burst = v.bu[1];  bus.m2_burst = v.bu[2];
    bus.sdram_ack = v.ack;   bus.sdram_complete = v.cmpl; bus.sdram_rdvalid = v.rdv;
    rd = $urandom();
    bus.sdram_rdata = rd;
    #1;
    e_cmpl = 3'b000;
    if (v.cmpl && sb.size() > 0) e_cmpl = 3'b001 << sb[0];
    chk(v.name, "sdram_req", bus.sdram_req, v.e_req);
    chk(v.name, "ack", {bus.m2_ack, bus.m1_ack, bus.m0_ack}, v.e_ack);
    chk(v.name, "complete", {bus.m2_complete, bus.m1_complete, bus.m0_complete}, e_cmpl);
    chk(v.name, "rdvalid", {bus.m2_rdvalid, bus.m1_rdvalid, bus.m0_rdvalid}, v.rdv);
    chk(v.name, "rdata", bus.rdata, rd);
    chk(v.name, "arb_error", bus.arb_error, v.e_err);
    if (v.e_req != 3'b000) begin
      g = oh_idx(v.e_req);
      chk(v.name, "addr", bus.sdram_addr, m_addr[g]);
      chk(v.name, "write", bus.sdram_write, v.wr[g]);
      chk(v.name, "burst", bus.sdram_burst, v.bu[g]);
      chk(v.name, "byte_en", bus.sdram_byte_enable, m_be[g]);
      chk(v.name, "wdata", bus.sdram_wdata, m_wd[g]);
    end
    if (v.cmpl && sb.size() > 0) void'(sb.pop_front());
    if (v.e_ack != 3'b000 && !v.wr[oh_idx(v.e_ack)]) sb.push_back(oh_idx(v.e_ack));
  endtask

  initial begin
    m_addr[0] = 26'h0000100; m_addr[1] = 26'h0000200; m_addr[2] = 26'h0000300;
    m_be[0] = 4'hF; m_be[1] = 4'h3; m_be[2] = 4'hC;
    m_wd[0] = 32'hA000_0000; m_wd[1] = 32'hB111_1111; m_wd[2] = 32'hC222_2222;
    bus.m0_addr = m_addr[0]; bus.m1_addr = m_addr[1]; bus.m2_addr = m_addr[2];
    bus.m0_byte_enable = m_be[0]; bus.m1_byte_enable = m_be[1]; bus.m2_byte_enable = m_be[2];
    bus.m0_wdata = m_wd[0]; bus.m1_wdata = m_wd[1]; bus.m2_wdata = m_wd[2];
    drive_idle();

    tbl.push_back(mk("rst", 0,0,0, 0,0,0, 0,0,0));
`ifdef SDRAM_ARB_VIDEO_PRIORITY_EN
    tbl.push_back(mk("pri", 5,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("pri", 5,0,0, 1,0,0, 4,4,0));
    tbl.push_back(mk("pri", 1,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("pri", 1,0,0, 1,0,0, 1,1,0));
    tbl.push_back(mk("pri", 7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("pri", 7,0,0, 1,0,0, 4,4,0));
    tbl.push_back(mk("pri", 3,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("pri", 3,0,0, 1,0,0, 2,2,0));
`else
    tbl.push_back(mk("rr", 7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("rr", 7,0,0, 1,0,0, 1,1,0));
    tbl.push_back(mk("rr", 7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("rr", 7,0,0, 1,0,0, 2,2,0));
    tbl.push_back(mk("rr", 7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("rr", 7,0,0, 1,0,0, 4,4,0));
    tbl.push_back(mk("rr", 7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("rr", 7,0,0, 1,0,0, 1,1,0));
`endif
    // Completion FIFO is now full: reads wait, a write still goes through.
    tbl.push_back(mk("full",    7,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("full_wr", 7,2,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("full_wr", 7,2,0, 1,0,0, 2,2,0));
    tbl.push_back(mk("full",    5,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("full_c",  5,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("full",    5,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("full",    5,0,0, 1,0,0, 4,4,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk("drain", 0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("idle",    0,0,0, 0,0,0, 0,0,0));
    // Single read: ack two cycles after the grant, completion four after the ack.
    tbl.push_back(mk("t1",      1,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("t1",      1,0,0, 0,0,0, 1,0,0));
    tbl.push_back(mk("t1",      1,0,0, 0,0,0, 1,0,0));
    tbl.push_back(mk("t1",      1,0,0, 1,0,0, 1,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk("t1", 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("t1_c",    0,0,0, 0,1,1, 0,0,0));
    tbl.push_back(mk("t1",      0,0,0, 0,0,0, 0,0,0));
    // Burst read blocks other masters until its completion.
    tbl.push_back(mk("burst",   2,0,2, 0,0,0, 0,0,0));
    tbl.push_back(mk("burst",   3,0,2, 1,0,0, 2,2,0));
    tbl.push_back(mk("wb",      1,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("wb",      1,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("wb_data", 1,0,0, 0,0,2, 0,0,0));
    tbl.push_back(mk("wb_c",    1,0,0, 0,1,2, 0,0,0));
    tbl.push_back(mk("wb_exit", 1,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("wb_exit", 1,0,0, 1,0,0, 1,1,0));
    tbl.push_back(mk("drain",   0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("idle",    0,0,0, 0,0,0, 0,0,0));
    // Single read ahead of a burst: first completion must not end the wait.
    tbl.push_back(mk("order",    4,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("order",    4,0,0, 1,0,0, 4,4,0));
    tbl.push_back(mk("order",    1,0,1, 0,0,0, 0,0,0));
    tbl.push_back(mk("order",    1,0,1, 1,0,0, 1,1,0));
    tbl.push_back(mk("order_wb", 2,2,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("order_c1", 2,2,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("order_wb", 2,2,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("order_c2", 2,2,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("order_go", 2,2,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("order_go", 2,2,0, 1,0,0, 2,2,0));
    tbl.push_back(mk("idle",     0,0,0, 0,0,0, 0,0,0));
    // Underflow is sticky; then park in WAIT_BURST ahead of the reset below.
    tbl.push_back(mk("err_empty",  0,0,0, 0,1,0, 0,0,0));
    tbl.push_back(mk("err_sticky", 0,0,0, 0,0,0, 0,0,1));
    tbl.push_back(mk("err_sticky", 0,0,0, 0,0,0, 0,0,1));
    tbl.push_back(mk("err_wb",     1,0,1, 0,0,0, 0,0,1));
    tbl.push_back(mk("err_wb",     1,0,1, 1,0,0, 1,1,1));
    tbl.push_back(mk("err_wb",     0,0,0, 0,0,0, 0,0,1));

    do_reset(2);
    foreach (tbl[i]) apply(tbl[i]);

    // Reset while waiting on a burst: IDLE, no grant, FIFO empty, error cleared.
    do_reset(1);
    apply(mk("post_rst",   2,2,0, 0,0,0, 0,0,0));
    apply(mk("post_rst",   2,2,0, 1,0,0, 2,2,0));
    apply(mk("post_rst_e", 0,0,0, 0,1,0, 0,0,0));
    apply(mk("post_rst_e", 0,0,0, 0,0,0, 0,0,1));

    // Controller ack with no grant outstanding.
    do_reset(1);
    apply(mk("ack_idle",   0,0,0, 1,0,0, 0,0,0));
    apply(mk("ack_idle",   0,0,0, 0,0,0, 0,0,1));
    apply(mk("ack_idle",   0,0,0, 0,0,0, 0,0,1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
